// File: rtl/usb_dpll.sv
// usb_dpll: oversampling digital PLL for the USB receive path. Recovers bit
// timing from d/se0, emits retimed bits on q/en and flags end-of-packet on eop.
module usb_dpll #(
  parameter int OSR          = 4,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  input  logic       se0,
  input  logic       usb_full_speed,
  output logic       q,
  output logic       en,
  output logic       eop,
  output logic       active,
  output logic       phase_err,
  output logic [1:0] state_dbg
);

  // Handshake: en is a valid-only strobe with no backpressure; the consumer
  // must take q in the single cycle en is high. eop is a separate strobe.

  localparam int            PW      = $clog2(OSR);
  localparam logic [PW-1:0] HALF    = PW'(OSR / 2);
  localparam logic [PW-1:0] LAST    = PW'(OSR - 1);
  localparam logic [PW-1:0] LAST_M1 = PW'(OSR - 2);
  localparam logic [1:0]    EOP_MIN = 2'(EOP_SE0_BITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SE0  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] ph, ph_nx, ph_inc, ph_skip;
  logic [1:0]    se0_cnt, se0_cnt_nx;
  logic          d_prev, se0_prev;
  logic          j, k, edge_det, sample, eop_ok;
  logic          q_nx, en_nx, eop_nx, perr_nx;

  assign j        = (usb_full_speed ? d : ~d) & ~se0;
  assign k        = ~j & ~se0;
  assign edge_det = (d != d_prev) & ~se0 & ~se0_prev;
  assign eop_ok   = (se0_cnt >= EOP_MIN);
  assign ph_inc   = (ph == LAST) ? '0 : ph + 1'b1;
  assign ph_skip  = (ph == LAST) ? PW'(1) : (ph == LAST_M1) ? '0 : ph + 2'd2;

  always_comb begin
    ph_nx = ph_inc;
    if (state == S_IDLE) begin
      ph_nx = k ? PW'(1) : '0;
    end else if (state == S_RUN && edge_det) begin
      if (ph != '0 && ph < HALF) ph_nx = ph;
      else if (ph > HALF)        ph_nx = ph_skip;
    end
  end

  // The decision is taken as ph is about to reach OSR/2, so the registered
  // q/en are presented while ph == OSR/2. Hold/skip can never jump over it.
  assign sample = (state != S_IDLE) && (ph_nx == HALF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ph        <= '0;
      se0_cnt   <= 2'd0;
      d_prev    <= 1'b0;
      se0_prev  <= 1'b0;
      q         <= 1'b0;
      en        <= 1'b0;
      eop       <= 1'b0;
      active    <= 1'b0;
      phase_err <= 1'b0;
    end else begin
      state     <= state_nx;
      ph        <= ph_nx;
      se0_cnt   <= se0_cnt_nx;
      d_prev    <= d;
      se0_prev  <= se0;
      q         <= q_nx;
      en        <= en_nx;
      eop       <= eop_nx;
      active    <= (state_nx != S_IDLE);
      phase_err <= perr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (k) state_nx = S_RUN;
      S_RUN:   if (sample && se0) state_nx = S_SE0;
      S_SE0:   if (sample && !se0) state_nx = (j && eop_ok) ? S_IDLE : S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    q_nx       = q;
    en_nx      = 1'b0;
    eop_nx     = 1'b0;
    perr_nx    = 1'b0;
    se0_cnt_nx = se0_cnt;
    case (state)
      S_IDLE: se0_cnt_nx = 2'd0;
      S_RUN: begin
        perr_nx = edge_det && (ph == HALF);
        if (sample) begin
          if (se0) begin
            se0_cnt_nx = 2'd1;
          end else begin
            q_nx  = d;
            en_nx = 1'b1;
          end
        end
      end
      S_SE0: begin
        if (sample) begin
          if (se0) begin
            se0_cnt_nx = (se0_cnt == 2'd3) ? 2'd3 : se0_cnt + 2'd1;
          end else if (j && eop_ok) begin
            eop_nx = 1'b1;
          end else begin
            q_nx  = d;
            en_nx = 1'b1;
          end
        end
      end
      default: se0_cnt_nx = 2'd0;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_usb_dpll.sv
// tb_usb_dpll: directed bench for usb_dpll with an OSR=4 full-speed instance
// and an OSR=8 low-speed instance sharing clock and reset.
module tb_usb_dpll;

  logic       clk = 1'b0;
  logic       reset;
  logic       d4, se0_4, fs4, q4, en4, eop4, act4, perr4;
  logic       d8, se0_8, fs8, q8, en8, eop8, act8, perr8;
  logic [1:0] st4, st8;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   viol = 0;
  int   en4_cyc[$];
  logic en4_q[$];
  int   eop4_cyc[$];
  logic eop4_act[$];
  int   perr4_n = 0;
  int   act4_low_n = 0;
  int   en8_cyc[$];
  logic en8_q[$];
  int   eop8_cyc[$];
  logic eop8_act[$];
  int   perr8_cyc[$];

  usb_dpll #(.OSR(4), .EOP_SE0_BITS(2)) dut4 (
    .clk(clk), .reset(reset), .d(d4), .se0(se0_4), .usb_full_speed(fs4),
    .q(q4), .en(en4), .eop(eop4), .active(act4), .phase_err(perr4),
    .state_dbg(st4)
  );

  usb_dpll #(.OSR(8), .EOP_SE0_BITS(2)) dut8 (
    .clk(clk), .reset(reset), .d(d8), .se0(se0_8), .usb_full_speed(fs8),
    .q(q8), .en(en8), .eop(eop8), .active(act8), .phase_err(perr8),
    .state_dbg(st8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output log, sampled on the falling edge
  always @(negedge clk) begin
    if (en4) begin en4_cyc.push_back(cyc); en4_q.push_back(q4); end
    if (eop4) begin eop4_cyc.push_back(cyc); eop4_act.push_back(act4); end
    if (perr4) perr4_n <= perr4_n + 1;
    if (!act4) act4_low_n <= act4_low_n + 1;
    if (en8) begin en8_cyc.push_back(cyc); en8_q.push_back(q8); end
    if (eop8) begin eop8_cyc.push_back(cyc); eop8_act.push_back(act8); end
    if (perr8) perr8_cyc.push_back(cyc);
    if ((en4 && eop4) || (en4 && !act4) || (en8 && eop8) || (en8 && !act8))
      viol <= viol + 1;
  end

  task automatic seg4(input logic dv, input logic s0, input int len);
    for (int i = 0; i < len; i++) begin
      d4 = dv; se0_4 = s0;
      @(posedge clk); #1;
    end
  endtask

  task automatic seg8(input logic dv, input logic s0, input int len);
    for (int i = 0; i < len; i++) begin
      d8 = dv; se0_8 = s0;
      @(posedge clk); #1;
    end
  endtask

  task automatic clear4();
    en4_cyc.delete(); en4_q.delete(); eop4_cyc.delete(); eop4_act.delete();
  endtask

  task automatic clear8();
    en8_cyc.delete(); en8_q.delete(); eop8_cyc.delete(); eop8_act.delete();
    perr8_cyc.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({q4, en4, eop4, act4, perr4, st4} !== 7'b0) begin
      n_bad++; $display("FAIL reset4: got %b expected 0000000", {q4, en4, eop4, act4, perr4, st4});
    end
    n_cmp++;
    if ({q8, en8, eop8, act8, perr8, st8} !== 7'b0) begin
      n_bad++; $display("FAIL reset8: got %b expected 0000000", {q8, en8, eop8, act8, perr8, st8});
    end
    reset = 1'b0;
    seg4(1'b1, 1'b0, 6);
    n_cmp++;
    if ({en4, eop4, act4, en8, eop8, act8} !== 6'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b expected 000000", {en4, eop4, act4, en8, eop8, act8});
    end
  endtask

  task automatic test_ideal();
    logic [7:0] pat;
    int t, p0;
    pat = 8'b1001_0110;
    clear4(); p0 = perr4_n; t = cyc;
    for (int i = 0; i < 8; i++) seg4(pat[i], 1'b0, 4);
    seg4(1'b0, 1'b1, 8);
    seg4(1'b1, 1'b0, 8);
    n_cmp++;
    if (en4_cyc.size() !== 8) begin
      n_bad++; $display("FAIL ideal_en_count: got %0d expected 8", en4_cyc.size());
    end
    for (int i = 0; i < 8 && i < en4_cyc.size(); i++) begin
      n_cmp++;
      if (en4_cyc[i] - t !== 2 + 4 * i) begin
        n_bad++; $display("FAIL ideal_en_cycle[%0d]: got %0d expected %0d", i, en4_cyc[i] - t, 2 + 4 * i);
      end
      n_cmp++;
      if (en4_q[i] !== pat[i]) begin
        n_bad++; $display("FAIL ideal_q[%0d]: got %b expected %b", i, en4_q[i], pat[i]);
      end
    end
    n_cmp++;
    if (eop4_cyc.size() !== 1 || eop4_cyc[0] - t !== 42 || eop4_act[0] !== 1'b0) begin
      n_bad++; $display("FAIL ideal_eop: got count %0d first %0d expected count 1 at 42 with active 0",
                        eop4_cyc.size(), eop4_cyc.size() > 0 ? eop4_cyc[0] - t : -1);
    end
    n_cmp++;
    if (perr4_n - p0 !== 0) begin
      n_bad++; $display("FAIL ideal_phase_err: got %0d expected 0", perr4_n - p0);
    end
  endtask

  task automatic test_late_early();
    int lens [8];
    int exp_en [8];
    int t;
    lens   = '{4, 4, 5, 4, 3, 4, 4, 4};
    exp_en = '{2, 6, 10, 15, 19, 22, 26, 30};
    clear4(); t = cyc;
    for (int i = 0; i < 8; i++) seg4(1'(i % 2), 1'b0, lens[i]);
    seg4(1'b0, 1'b1, 8);
    seg4(1'b1, 1'b0, 8);
    n_cmp++;
    if (en4_cyc.size() !== 8) begin
      n_bad++; $display("FAIL corr_en_count: got %0d expected 8", en4_cyc.size());
    end
    for (int i = 0; i < 8 && i < en4_cyc.size(); i++) begin
      n_cmp++;
      if (en4_cyc[i] - t !== exp_en[i]) begin
        n_bad++; $display("FAIL corr_en_cycle[%0d]: got %0d expected %0d", i, en4_cyc[i] - t, exp_en[i]);
      end
      n_cmp++;
      if (en4_q[i] !== 1'(i % 2)) begin
        n_bad++; $display("FAIL corr_q[%0d]: got %b expected %b", i, en4_q[i], 1'(i % 2));
      end
    end
    n_cmp++;
    if (eop4_cyc.size() !== 1 || eop4_cyc[0] - t !== 42) begin
      n_bad++; $display("FAIL corr_eop: got count %0d expected 1 at 42", eop4_cyc.size());
    end
  endtask

  task automatic test_se0_glitch();
    int exp_en [7];
    logic exp_q [7];
    int t, a0, a1;
    exp_en = '{2, 6, 10, 14, 22, 26, 30};
    exp_q  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    clear4(); t = cyc;
    seg4(1'b0, 1'b0, 1);
    a0 = act4_low_n;
    seg4(1'b0, 1'b0, 3);
    seg4(1'b1, 1'b0, 4);
    seg4(1'b0, 1'b0, 4);
    seg4(1'b1, 1'b0, 4);
    seg4(1'b0, 1'b1, 4);
    seg4(1'b0, 1'b0, 4);
    seg4(1'b1, 1'b0, 4);
    seg4(1'b0, 1'b0, 4);
    seg4(1'b0, 1'b1, 8);
    seg4(1'b1, 1'b0, 1);
    a1 = act4_low_n;
    seg4(1'b1, 1'b0, 7);
    n_cmp++;
    if (en4_cyc.size() !== 7) begin
      n_bad++; $display("FAIL glitch_en_count: got %0d expected 7", en4_cyc.size());
    end
    for (int i = 0; i < 7 && i < en4_cyc.size(); i++) begin
      n_cmp++;
      if (en4_cyc[i] - t !== exp_en[i] || en4_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL glitch_en[%0d]: got cycle %0d q %b expected cycle %0d q %b",
                          i, en4_cyc[i] - t, en4_q[i], exp_en[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (a1 - a0 !== 0) begin
      n_bad++; $display("FAIL glitch_active: got %0d low cycles expected 0", a1 - a0);
    end
    n_cmp++;
    if (eop4_cyc.size() !== 1 || eop4_cyc[0] - t !== 42) begin
      n_bad++; $display("FAIL glitch_eop: got count %0d expected only the final one at 42", eop4_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    int t, ne;
    clear4(); t = cyc;
    seg4(1'b0, 1'b0, 4);
    seg4(1'b1, 1'b0, 2);
    n_cmp++;
    if ({en4, q4, act4} !== 3'b111) begin
      n_bad++; $display("FAIL mid_before_reset: got %b expected 111", {en4, q4, act4});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({q4, en4, eop4, act4, perr4, st4} !== 7'b0) begin
      n_bad++; $display("FAIL mid_reset_clear: got %b expected 0000000", {q4, en4, eop4, act4, perr4, st4});
    end
    ne = en4_cyc.size();
    @(posedge clk); #1;
    reset = 1'b0;
    seg4(1'b1, 1'b0, 4);
    n_cmp++;
    if (en4_cyc.size() !== ne || eop4_cyc.size() !== 0) begin
      n_bad++; $display("FAIL mid_trailing: got en %0d eop %0d expected en %0d eop 0",
                        en4_cyc.size(), eop4_cyc.size(), ne);
    end
    clear4(); t = cyc;
    seg4(1'b0, 1'b0, 4);
    seg4(1'b1, 1'b0, 4);
    seg4(1'b0, 1'b1, 8);
    seg4(1'b1, 1'b0, 8);
    n_cmp++;
    if (en4_cyc.size() !== 2 || en4_cyc[0] - t !== 2 || en4_q[0] !== 1'b0) begin
      n_bad++; $display("FAIL mid_restart: got count %0d first %0d expected count 2 first 2 q 0",
                        en4_cyc.size(), en4_cyc.size() > 0 ? en4_cyc[0] - t : -1);
    end
    n_cmp++;
    if (eop4_cyc.size() !== 1 || eop4_cyc[0] - t !== 18) begin
      n_bad++; $display("FAIL mid_restart_eop: got count %0d expected 1 at 18", eop4_cyc.size());
    end
  endtask

  task automatic test_osr8_jitter();
    int lens [10];
    int exp_en [10];
    int t, gap;
    lens   = '{8, 9, 7, 7, 9, 9, 7, 7, 9, 8};
    exp_en = '{4, 12, 21, 28, 35, 44, 53, 60, 67, 76};
    clear8(); t = cyc;
    for (int i = 0; i < 10; i++) seg8(1'((i + 1) % 2), 1'b0, lens[i]);
    seg8(1'b0, 1'b1, 16);
    seg8(1'b0, 1'b0, 16);
    n_cmp++;
    if (en8_cyc.size() !== 10) begin
      n_bad++; $display("FAIL jit_en_count: got %0d expected 10", en8_cyc.size());
    end
    for (int i = 0; i < 10 && i < en8_cyc.size(); i++) begin
      n_cmp++;
      if (en8_cyc[i] - t !== exp_en[i] || en8_q[i] !== 1'((i + 1) % 2)) begin
        n_bad++; $display("FAIL jit_en[%0d]: got cycle %0d q %b expected cycle %0d q %b",
                          i, en8_cyc[i] - t, en8_q[i], exp_en[i], 1'((i + 1) % 2));
      end
      if (i > 0) begin
        gap = en8_cyc[i] - en8_cyc[i-1];
        n_cmp++;
        if (gap < 7 || gap > 9) begin
          n_bad++; $display("FAIL jit_gap[%0d]: got %0d expected 7..9", i, gap);
        end
      end
    end
    n_cmp++;
    if (eop8_cyc.size() !== 1 || eop8_cyc[0] - t !== 100 || eop8_act[0] !== 1'b0) begin
      n_bad++; $display("FAIL jit_eop: got count %0d expected 1 at 100 with active 0", eop8_cyc.size());
    end
    n_cmp++;
    if (perr8_cyc.size() !== 0) begin
      n_bad++; $display("FAIL jit_phase_err: got %0d expected 0", perr8_cyc.size());
    end
  endtask

  task automatic test_phase_err();
    int lens [4];
    int t;
    lens = '{4, 12, 8, 8};
    clear8(); t = cyc;
    for (int i = 0; i < 4; i++) seg8(1'((i + 1) % 2), 1'b0, lens[i]);
    seg8(1'b0, 1'b1, 16);
    seg8(1'b0, 1'b0, 16);
    n_cmp++;
    if (perr8_cyc.size() !== 1 || perr8_cyc[0] - t !== 5) begin
      n_bad++; $display("FAIL perr_pulse: got count %0d first %0d expected count 1 at 5",
                        perr8_cyc.size(), perr8_cyc.size() > 0 ? perr8_cyc[0] - t : -1);
    end
    n_cmp++;
    if (en8_cyc.size() !== 4) begin
      n_bad++; $display("FAIL perr_en_count: got %0d expected 4", en8_cyc.size());
    end
    for (int i = 0; i < 4 && i < en8_cyc.size(); i++) begin
      n_cmp++;
      if (en8_cyc[i] - t !== 4 + 8 * i || en8_q[i] !== 1'((i + 1) % 2)) begin
        n_bad++; $display("FAIL perr_en[%0d]: got cycle %0d q %b expected cycle %0d q %b",
                          i, en8_cyc[i] - t, en8_q[i], 4 + 8 * i, 1'((i + 1) % 2));
      end
    end
    n_cmp++;
    if (eop8_cyc.size() !== 1 || eop8_cyc[0] - t !== 52) begin
      n_bad++; $display("FAIL perr_eop: got count %0d expected 1 at 52", eop8_cyc.size());
    end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (viol !== 0) begin
      n_bad++; $display("FAIL strobe_invariants: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    reset = 1'b1;
    d4 = 1'b1; se0_4 = 1'b0; fs4 = 1'b1;
    d8 = 1'b0; se0_8 = 1'b0; fs8 = 1'b0;
    test_reset();
    test_ideal();
    test_late_early();
    test_se0_glitch();
    test_reset_mid();
    test_osr8_jitter();
    test_phase_err();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
